// File: rtl/alu_secuencial.sv
// alu_secuencial: registered ALU with a multi-cycle shift-add multiply.
//
// Executes one operation per start request. Single-cycle ops register their
// result one edge after start; the multiply iterates once per clock for WIDTH
// clocks with busy high, then registers its result. valid pulses for one cycle
// whenever alu_result and the flags are updated.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   operation request, accepted only while busy=0
//   alu_control  in   3-bit operation code, sampled with start
//   src_a        in   WIDTH-bit operand A, sampled with start
//   src_b        in   WIDTH-bit operand B, sampled with start
//   busy         out  high while a multiply is in progress
//   valid        out  one-cycle pulse when result/flags are updated
//   alu_result   out  registered WIDTH-bit result
//   flag_zero    out  alu_result == 0
//   flag_carry   out  adder carry-out (add/sub only)
//   flag_ovf     out  signed overflow (add/sub only)
module alu_secuencial #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [WIDTH-1:0] mul_step;

  logic             accept, mul_go, mul_done;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   sum;
  logic             is_sub;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0] op_result;
  logic             op_carry, op_ovf;

  assign busy     = (state == MUL);
  assign accept   = (state == IDLE) && start;
  assign mul_go   = accept && (alu_control == 3'b111) && MUL_EN;
  assign mul_done = (state == MUL) && (counter == LAST);

  // Accumulator value including the current iteration; on the final edge this
  // is the product written to alu_result.
  assign mul_step = acc + (b_sh[0] ? a_sh : '0);

  // Single-cycle operation datapath. Subtraction reuses the adder with an
  // inverted B and carry-in, so the carry flag means "no borrow".
  always_comb begin
    is_sub     = (alu_control == 3'b001);
    b_in       = is_sub ? ~src_b : src_b;
    sum        = {1'b0, src_a} + {1'b0, b_in} + {{WIDTH{1'b0}}, is_sub};
    a_s        = src_a;
    b_s        = src_b;
    op_result  = '0;
    op_carry   = 1'b0;
    op_ovf     = 1'b0;
    case (alu_control)
      3'b000, 3'b001: begin
        op_result = sum[WIDTH-1:0];
        op_carry  = sum[WIDTH];
        op_ovf    = (src_a[WIDTH-1] == b_in[WIDTH-1]) &&
                    (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      3'b010:  op_result = src_a & src_b;
      3'b011:  op_result = src_a | src_b;
      3'b100:  op_result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      3'b101:  op_result = {{(WIDTH-1){1'b0}}, (src_a == src_b)};
      3'b110:  op_result = {{(WIDTH-1){1'b0}}, (src_a != src_b)};
      default: op_result = '0;  // multiply disabled: single-cycle zero
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_go) state_next = MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      valid      <= 1'b0;
      alu_result <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      state <= state_next;
      valid <= 1'b0;
      if (mul_go) begin
        counter <= '0;
      end else if (accept) begin
        alu_result <= op_result;
        flag_zero  <= (op_result == '0);
        flag_carry <= op_carry;
        flag_ovf   <= op_ovf;
        valid      <= 1'b1;
      end else if (state == MUL) begin
        counter <= counter + CNT_W'(1);
        if (mul_done) begin
          alu_result <= mul_step;
          flag_zero  <= (mul_step == '0);
          flag_carry <= 1'b0;
          flag_ovf   <= 1'b0;
          valid      <= 1'b1;
        end
      end
    end
  end

  // Shift-add operand registers: pure datapath, loaded on the accepting edge.
  always_ff @(posedge clk) begin
    if (mul_go) begin
      a_sh <= src_a;
      b_sh <= src_b;
      acc  <= '0;
    end else if (state == MUL) begin
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      acc  <= mul_step;
    end
  end

endmodule
